// File: rtl/fibo_pkg.sv
// Shared types and constants for the generalised Fibonacci engine.
package fibo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_WIDTH   = 16;
  localparam int unsigned DEF_N_WIDTH = 5;

  // Seed pairs for the two common sequences
  localparam int unsigned FIB_SEED0   = 0;
  localparam int unsigned FIB_SEED1   = 1;
  localparam int unsigned LUCAS_SEED0 = 2;
  localparam int unsigned LUCAS_SEED1 = 1;

endpackage

// File: rtl/fibo_step_dp.sv
// Recurrence datapath: holds the current term pair (a, b) with their
// overflow tags, and either loads fresh seeds or advances by one term.
module fibo_step_dp #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] seed0_i,
  input  logic [WIDTH-1:0] seed1_i,
  output logic [WIDTH-1:0] a_o,
  output logic             ova_o
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             ova_q, ova_d;
  logic             ovb_q, ovb_d;
  logic [WIDTH:0]   sum;

  assign sum = {1'b0, a_q} + {1'b0, b_q};

  // Next term pair: load seeds, or shift b into a and the sum into b.
  // ovb is sticky across the chain so a carry anywhere upstream of a term
  // marks that term, while a carry only in term n+1 never reaches a.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    ova_d = ova_q;
    ovb_d = ovb_q;
    if (load_i) begin
      a_d   = seed0_i;
      b_d   = seed1_i;
      ova_d = 1'b0;
      ovb_d = 1'b0;
    end else if (step_i) begin
      a_d   = b_q;
      b_d   = sum[WIDTH-1:0];
      ova_d = ovb_q;
      ovb_d = sum[WIDTH] | ova_q | ovb_q;
    end
  end

  // Term pair registers with synchronous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      ova_q <= 1'b0;
      ovb_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      ova_q <= ova_d;
      ovb_q <= ovb_d;
    end
  end

  assign a_o   = a_q;
  assign ova_o = ova_q;

endmodule

// File: rtl/fibo_seq_engine.sv
// Generalised Fibonacci engine: computes term n of a two-seed recurrence
// with overflow detection, optional saturation and a done/ack handshake.
module fibo_seq_engine
  import fibo_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned N_WIDTH  = DEF_N_WIDTH,
  parameter bit          SATURATE = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N_WIDTH-1:0] n,
  input  logic [WIDTH-1:0]   seed0,
  input  logic [WIDTH-1:0]   seed1,
  input  logic               ack,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               overflow
);

  state_e             state_q, state_d;
  logic [N_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               overflow_q, overflow_d;
  logic               dp_load, dp_step;
  logic [WIDTH-1:0]   dp_a;
  logic               dp_ova;

  fibo_step_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk     (clk),
    .reset   (reset),
    .load_i  (dp_load),
    .step_i  (dp_step),
    .seed0_i (seed0),
    .seed1_i (seed1),
    .a_o     (dp_a),
    .ova_o   (dp_ova)
  );

  // Next-state, counter, result capture and datapath control.
  // A start in DONE acts as an implicit ack and reloads directly.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    dp_load    = 1'b0;
    dp_step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          dp_load = 1'b1;
          cnt_d   = n;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_q != '0) begin
          dp_step = 1'b1;
          cnt_d   = cnt_q - N_WIDTH'(1);
        end else begin
          result_d   = (SATURATE && dp_ova) ? '1 : dp_a;
          overflow_d = dp_ova;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (start) begin
          dp_load = 1'b1;
          cnt_d   = n;
          state_d = CALC;
        end else if (ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers with synchronous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q == CALC);
  assign done     = (state_q == DONE);
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_fibo_seq_engine.sv
// Directed bench for fibo_seq_engine: a wrapping and a saturating instance
// share all inputs and are checked against hand-computed terms.
module tb_fibo_seq_engine;
  import fibo_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned NW = 5;

  logic          clk = 1'b0;
  logic          reset, start, ack;
  logic [NW-1:0] n;
  logic [W-1:0]  seed0, seed1;
  logic          busy, done, overflow;
  logic [W-1:0]  result;
  logic          s_busy, s_done, s_overflow;
  logic [W-1:0]  s_result;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fibo_seq_engine #(
    .WIDTH    (W),
    .N_WIDTH  (NW),
    .SATURATE (1'b0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .n        (n),
    .seed0    (seed0),
    .seed1    (seed1),
    .ack      (ack),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow)
  );

  fibo_seq_engine #(
    .WIDTH    (W),
    .N_WIDTH  (NW),
    .SATURATE (1'b1)
  ) dut_sat (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .n        (n),
    .seed0    (seed0),
    .seed1    (seed1),
    .ack      (ack),
    .busy     (s_busy),
    .done     (s_done),
    .result   (s_result),
    .overflow (s_overflow)
  );

  // Advance one edge and settle past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present start for exactly one edge (the accepting edge T0)
  task automatic kick(input int nv, input int s0, input int s1);
    n     = NW'(nv);
    seed0 = W'(s0);
    seed1 = W'(s1);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Count edges after T0 until done is seen, bounded
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 200) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; ack = 1'b0; n = '0; seed0 = '0; seed1 = '0;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b result=%0d ovf=%b expected 0 0 0 0",
               busy, done, result, overflow);
    end
  endtask

  task automatic test_fib();
    int nv  [4] = '{5, 9, 12, 18};
    int exp [4] = '{5, 34, 144, 2584};
    int cyc;
    for (int i = 0; i < 4; i++) begin
      kick(nv[i], FIB_SEED0, FIB_SEED1);
      wait_done(cyc);
      checks++;
      if (cyc !== nv[i] + 1) begin
        failures++;
        $display("FAIL fib_latency n=%0d: got %0d cycles expected %0d", nv[i], cyc, nv[i] + 1);
      end
      checks++;
      if (result !== W'(exp[i]) || overflow !== 1'b0) begin
        failures++;
        $display("FAIL fib_result n=%0d: got %0d ovf=%b expected %0d ovf=0",
                 nv[i], result, overflow, exp[i]);
      end
    end
  endtask

  task automatic test_edges();
    int cyc;
    kick(0, FIB_SEED0, FIB_SEED1);
    wait_done(cyc);
    checks++;
    if (cyc !== 1 || result !== 16'd0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL n0: cycles=%0d result=%0d ovf=%b expected 1 0 0", cyc, result, overflow);
    end
    kick(1, FIB_SEED0, FIB_SEED1);
    wait_done(cyc);
    checks++;
    if (cyc !== 2 || result !== 16'd1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL n1: cycles=%0d result=%0d ovf=%b expected 2 1 0", cyc, result, overflow);
    end
    kick(9, LUCAS_SEED0, LUCAS_SEED1);
    wait_done(cyc);
    checks++;
    if (result !== 16'd76) begin
      failures++;
      $display("FAIL lucas9: got %0d expected 76", result);
    end
  endtask

  task automatic test_overflow();
    int cyc;
    kick(24, FIB_SEED0, FIB_SEED1);
    wait_done(cyc);
    checks++;
    if (result !== 16'd46368 || overflow !== 1'b0 || s_result !== 16'd46368 || s_overflow !== 1'b0) begin
      failures++;
      $display("FAIL fib24: wrap=%0d/%b sat=%0d/%b expected 46368/0 both",
               result, overflow, s_result, s_overflow);
    end
    kick(25, FIB_SEED0, FIB_SEED1);
    wait_done(cyc);
    checks++;
    if (result !== 16'd9489 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL fib25_wrap: got %0d ovf=%b expected 9489 ovf=1", result, overflow);
    end
    checks++;
    if (s_result !== 16'd65535 || s_overflow !== 1'b1 || s_done !== 1'b1) begin
      failures++;
      $display("FAIL fib25_sat: got %0d ovf=%b done=%b expected 65535 ovf=1 done=1",
               s_result, s_overflow, s_done);
    end
  endtask

  task automatic test_handshake();
    int cyc;
    kick(5, FIB_SEED0, FIB_SEED1);
    wait_done(cyc);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || result !== 16'd5) begin
        failures++;
        $display("FAIL hold%0d: done=%b busy=%b result=%0d expected 1 0 5", i, done, busy, result);
      end
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== 16'd5) begin
      failures++;
      $display("FAIL ack: done=%b busy=%b result=%0d expected 0 0 5", done, busy, result);
    end
    // ack while idle must not disturb anything
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== 16'd5) begin
      failures++;
      $display("FAIL ack_idle: done=%b busy=%b result=%0d expected 0 0 5", done, busy, result);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    kick(5, FIB_SEED0, FIB_SEED1);
    wait_done(cyc);
    kick(12, FIB_SEED0, FIB_SEED1);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_state: busy=%b done=%b expected 1 0", busy, done);
    end
    wait_done(cyc);
    checks++;
    if (cyc !== 13 || result !== 16'd144) begin
      failures++;
      $display("FAIL b2b_result: cycles=%0d result=%0d expected 13 144", cyc, result);
    end
  endtask

  task automatic test_mid_calc();
    int cyc;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    kick(18, FIB_SEED0, FIB_SEED1);
    tick();
    tick();
    kick(5, LUCAS_SEED0, LUCAS_SEED1);
    cyc = 3;
    while (!done && cyc < 200) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== 19 || result !== 16'd2584) begin
      failures++;
      $display("FAIL start_ignored: cycles=%0d result=%0d expected 19 2584", cyc, result);
    end
    kick(18, FIB_SEED0, FIB_SEED1);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 16'd0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: busy=%b done=%b result=%0d ovf=%b expected 0 0 0 0",
               busy, done, result, overflow);
    end
    kick(5, FIB_SEED0, FIB_SEED1);
    wait_done(cyc);
    checks++;
    if (cyc !== 6 || result !== 16'd5) begin
      failures++;
      $display("FAIL after_reset: cycles=%0d result=%0d expected 6 5", cyc, result);
    end
  endtask

  // busy and done must never be high together on either instance
  always @(negedge clk) begin
    if (reset === 1'b0 && ((busy && done) || (s_busy && s_done))) begin
      checks++;
      failures++;
      $display("FAIL busy_done_excl: busy=%b done=%b sat_busy=%b sat_done=%b",
               busy, done, s_busy, s_done);
    end
  end

  initial begin
    #3;
    test_reset();
    test_fib();
    test_edges();
    test_overflow();
    test_handshake();
    test_back_to_back();
    test_mid_calc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
